// File: rtl/deplasare_ctrl.sv
// deplasare_ctrl -- position sequencer for the 6x7-segment chase display.
//
// Walks a single lit segment around the perimeter of a bank of DISPLAY_COUNT
// displays: along the top row left to right, down the last display, along the
// bottom row right to left and back up the first display (clockwise), or the
// reverse path (counter-clockwise). A prescaler turns the system clock into
// step ticks at a rate selectable by speed_i.
//
// Parameters
//   DISPLAY_COUNT  number of displays in the bank (N)
//   STEP_DIV       clock cycles per step at speed_i = 0 (must be >= 8)
//   COL_WIDTH      column index width
//
// Ports
//   clk_i      system clock
//   rst_ni     synchronous active-low reset
//   en_i       1 = run, 0 = freeze position and prescaler
//   dir_i      0 = clockwise, 1 = counter-clockwise (sampled on each tick)
//   speed_i    effective divider is STEP_DIV >> speed_i
//   restart_i  synchronous return to home (row 1, col 0), no lap pulse
//   row_o      1 = top segment row, 0 = bottom; this is the FSM state itself
//   col_o      active display index, always 0..N-1
//   step_o     one-cycle pulse with every position change
//   lap_o      one-cycle pulse when the position re-enters home
module deplasare_ctrl #(
  parameter int DISPLAY_COUNT = 6,
  parameter int STEP_DIV      = 12_500_000,
  parameter int COL_WIDTH     = $clog2(DISPLAY_COUNT)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 dir_i,
  input  logic [1:0]           speed_i,
  input  logic                 restart_i,
  output logic                 row_o,
  output logic [COL_WIDTH-1:0] col_o,
  output logic                 step_o,
  output logic                 lap_o
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(DISPLAY_COUNT - 1);

  // TOP = segment on the top row, BOT = bottom row.
  typedef enum logic {
    BOT = 1'b0,
    TOP = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [COL_WIDTH-1:0] col_q, col_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [31:0]          div_eff;
  logic                 tick;
  logic                 lap_d;

  // Prescaler compare. Using >= rather than == means a divider lowered
  // mid-count fires immediately instead of waiting for a counter wrap.
  always_comb begin
    div_eff = 32'(STEP_DIV) >> speed_i;
    tick    = en_i & (32'(cnt_q) >= (div_eff - 32'd1));
  end

  // Next position. At the end of a row only the row flips; the column is
  // kept so the walk turns the corner through the same display.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    case (state_q)
      TOP: begin
        if (!dir_i) begin
          if (col_q < COL_LAST) col_d = col_q + COL_WIDTH'(1);
          else                  state_d = BOT;
        end else begin
          if (col_q > '0)       col_d = col_q - COL_WIDTH'(1);
          else                  state_d = BOT;
        end
      end
      BOT: begin
        if (!dir_i) begin
          if (col_q > '0)       col_d = col_q - COL_WIDTH'(1);
          else                  state_d = TOP;
        end else begin
          if (col_q < COL_LAST) col_d = col_q + COL_WIDTH'(1);
          else                  state_d = TOP;
        end
      end
      default: begin
        state_d = TOP;
        col_d   = '0;
      end
    endcase
    lap_d = (state_d == TOP) && (col_d == '0);
  end

  // Restart shares the reset path so it overrides a simultaneous tick and
  // never produces a lap pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || restart_i) begin
      state_q <= TOP;
      col_q   <= '0;
      cnt_q   <= '0;
      step_o  <= 1'b0;
      lap_o   <= 1'b0;
    end else begin
      step_o <= tick;
      lap_o  <= tick & lap_d;
      if (tick) begin
        cnt_q   <= '0;
        state_q <= state_d;
        col_q   <= col_d;
      end else if (en_i) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign row_o = (state_q == TOP);
  assign col_o = col_q;

endmodule

// File: doc/deplasare_ctrl.md
# deplasare_ctrl

Sequencer for the 6×7-segment chase display. It generates the `row_i`/`col_i` position pair consumed by the display-shift block, so a single lit segment travels around the perimeter of the display bank at a programmable rate. It sits between the board switches/keys and the display-shift block, and also exports step and lap strobes for the LED shift logic.

## Interface
- `DISPLAY_COUNT`, default 6: number of displays in the bank.
- `STEP_DIV`, default 12_500_000: clock cycles per step at `speed_i`=0 (4 Hz at 50 MHz). Must be ≥ 8.
- `COL_WIDTH`, default `$clog2(DISPLAY_COUNT)`: column index width.
- `clk_i`  in  1  system clock; the only clock.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `en_i`  in  1  1 = run, 0 = freeze the position and the prescaler.
- `dir_i`  in  1  0 = clockwise, 1 = counter-clockwise.
- `speed_i`  in  2  effective divider is `STEP_DIV >> speed_i`.
- `restart_i`  in  1  synchronous return to the home position.
- `row_o`  out  1  to display `row_i`: 1 = top segment row, 0 = bottom.
- `col_o`  out  COL_WIDTH  to display `col_i`: active display index.
- `step_o`  out  1  one-cycle pulse, coincident with each position change.
- `lap_o`  out  1  one-cycle pulse when the position re-enters home.

## Operation
- Position state is {row, col}. Home is row=1, col=0.
- Clockwise path: (1,0)→(1,1)→…→(1,N-1)→(0,N-1)→(0,N-2)→…→(0,0)→(1,0), where N = `DISPLAY_COUNT`. One lap is 2N steps.
- Counter-clockwise path: the exact reverse of the clockwise path.
- FSM states: TOP (row=1) and BOT (row=0).
  - Clockwise, TOP: if col < N-1, col+1; else go to BOT, col unchanged.
  - Clockwise, BOT: if col > 0, col-1; else go to TOP, col unchanged.
  - Counter-clockwise, TOP: if col > 0, col-1; else go to BOT, col unchanged.
  - Counter-clockwise, BOT: if col < N-1, col+1; else go to TOP, col unchanged.
- `dir_i` is sampled on each step tick. A change reverses the walk from the current position, with no jump.
- Prescaler:
  - Counter width is `$clog2(STEP_DIV)`. `div_eff = STEP_DIV >> speed_i`, always ≥ 1.
  - The counter increments only while `en_i`=1.
  - tick = en_i & (cnt ≥ div_eff-1). On a tick, cnt←0.
  - The ≥ comparison means lowering the divider mid-count fires at once and never waits for the counter to wrap.
- `lap_o` asserts on the step whose new position is home, in either direction.
- `col_o` never leaves the range 0..N-1, including for non-power-of-2 N.

## Timing
- Reset (`rst_ni`=0 at an edge): row_o=1, col_o=0, step_o=0, lap_o=0, cnt=0, FSM=TOP.
- Every output is registered. Position, `step_o` and `lap_o` update on the same edge, the one after the tick condition holds.
- Step period is exactly `div_eff` cycles while `en_i` stays 1. The first step after reset or restart happens `div_eff` enabled cycles later.
- `en_i` falling: cnt and position hold. `step_o` is 0 from the next edge. Resuming continues the partial count; it does not restart it.
- `restart_i`: takes effect at the next edge and forces the reset values. It has priority over a simultaneous tick. No `lap_o` is generated by a restart.
- Reset asserted mid-step: the partial count is discarded and the outputs return to the reset values on that edge.
- `speed_i` change: takes effect on the next cycle's comparison.

## Test plan
Test bench settings: N=6, STEP_DIV=8, `speed_i`=1 (div_eff=4), unless a scenario says otherwise.
1. Reset, then `en_i`=1, `dir_i`=0 for 48 cycles.
   - Required: 12 `step_o` pulses, spaced 4 cycles apart.
   - Positions in order: (1,1),(1,2),(1,3),(1,4),(1,5),(0,5),(0,4),(0,3),(0,2),(0,1),(0,0),(1,0).
   - `lap_o` pulses only on the final (1,0) step.
2. Counter-clockwise from reset, `dir_i`=1.
   - Required first steps: (0,0),(0,1),…,(0,5),(1,5),(1,4),…
   - `lap_o` on step 12.
3. Flip `dir_i` 0→1 while at (1,3).
   - Required next steps: (1,2), then (1,1). No skipped or repeated position.
4. Drop `en_i` for 10 cycles when cnt=2, then raise it.
   - Required: no step while paused. The next step comes 2 enabled cycles after the resume.
5. Change `speed_i` 0→3 when cnt=5 (div_eff goes 8→1).
   - Required: a step on the next edge, then a step on every cycle.
6. `restart_i` asserted on a tick cycle at (0,2); separately, `rst_ni`=0 mid-count.
   - Required: (1,0) on the following edge, `step_o`=0, `lap_o`=0.
   - The next step occurs exactly div_eff cycles later.
